// File: rtl/systick_alarm.sv
// systick_alarm: NUM_CHANNELS compare alarms sharing one wrap-safe comparator via a round-robin scanner.
// Define ALARM_PERIODIC_EN to add per-channel reload-period registers (PERi).
module systick_alarm #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tick_count,
  output logic [31:0] data_bus_read,
  input  logic [31:0] data_bus_write,
  input  logic [31:0] data_bus_addr,
  input  logic        data_bus_select,
  input  logic [1:0]  data_bus_mode,
  output logic        irq
);

  localparam int N = NUM_CHANNELS;
  localparam logic [3:0] W_CTRL = 4'd8;
  localparam logic [3:0] W_PEND = 4'd9;
  localparam logic [3:0] W_MASK = 4'd10;

  logic [31:0]  cmp_reg  [N];
  logic [31:0]  cmp_next [N];
`ifdef ALARM_PERIODIC_EN
  logic [31:0]  per_reg  [N];
  logic [31:0]  per_next [N];
  logic [N-1:0] wr_per;
`endif
  logic [N-1:0] en_reg, en_next;
  logic [N-1:0] pend_reg, pend_next;
  logic [N-1:0] mask_reg, mask_next;
  logic [1:0]   idx_reg, idx_next;
  logic         irq_reg;

  logic [3:0]   word;
  logic         wr_en;
  logic [N-1:0] wr_cmp;
  logic [31:0]  diff;
  logic         hit;
  logic         collide;
  logic         unused_addr;

  assign word        = data_bus_addr[5:2];
  assign wr_en       = data_bus_select && (data_bus_mode == 2'b10);
  assign unused_addr = ^{data_bus_addr[31:6], data_bus_addr[1:0]};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign wr_cmp[gi] = wr_en && (word == 4'(gi));
`ifdef ALARM_PERIODIC_EN
      assign wr_per[gi] = wr_en && (word == 4'(gi + 4));
`endif
    end
  endgenerate

  // Modular difference: the alarm is due once tick_count is within 2^31 ticks at or past CMP.
  assign diff = tick_count - cmp_reg[idx_reg];
  assign hit  = en_reg[idx_reg] && !pend_reg[idx_reg] && !diff[31];

  // A bus write touching the channel under evaluation wins; the scanner retries next lap.
`ifdef ALARM_PERIODIC_EN
  assign collide = wr_cmp[idx_reg] || wr_per[idx_reg] || (wr_en && word == W_CTRL);
`else
  assign collide = wr_cmp[idx_reg] || (wr_en && word == W_CTRL);
`endif

  assign idx_next = (idx_reg == 2'(N - 1)) ? 2'd0 : idx_reg + 2'd1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cmp_next[i] = cmp_reg[i];
`ifdef ALARM_PERIODIC_EN
      per_next[i] = per_reg[i];
`endif
    end
    en_next   = en_reg;
    pend_next = pend_reg;
    mask_next = mask_reg;

    for (int i = 0; i < N; i++) begin
      if (wr_cmp[i]) cmp_next[i] = data_bus_write;
`ifdef ALARM_PERIODIC_EN
      if (wr_per[i]) per_next[i] = data_bus_write;
`endif
    end
    if (wr_en) begin
      case (word)
        W_CTRL:  en_next   = data_bus_write[N-1:0];
        W_PEND:  pend_next = pend_reg & ~data_bus_write[N-1:0];
        W_MASK:  mask_next = data_bus_write[N-1:0];
        default: ;
      endcase
    end

    // Applied after the bus update so a set beats a simultaneous W1C.
    if (hit && !collide) begin
      pend_next[idx_reg] = 1'b1;
`ifdef ALARM_PERIODIC_EN
      if (per_reg[idx_reg] != 32'd0)
        cmp_next[idx_reg] = cmp_reg[idx_reg] + per_reg[idx_reg];
      else
        en_next[idx_reg] = 1'b0;
`else
      en_next[idx_reg] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        cmp_reg[i] <= '0;
`ifdef ALARM_PERIODIC_EN
        per_reg[i] <= '0;
`endif
      end
      en_reg   <= '0;
      pend_reg <= '0;
      mask_reg <= '0;
      idx_reg  <= '0;
      irq_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cmp_reg[i] <= cmp_next[i];
`ifdef ALARM_PERIODIC_EN
        per_reg[i] <= per_next[i];
`endif
      end
      en_reg   <= en_next;
      pend_reg <= pend_next;
      mask_reg <= mask_next;
      idx_reg  <= idx_next;
      irq_reg  <= |(pend_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  always_comb begin
    data_bus_read = '0;
    for (int i = 0; i < N; i++) begin
      if (word == 4'(i)) data_bus_read = cmp_reg[i];
`ifdef ALARM_PERIODIC_EN
      if (word == 4'(i + 4)) data_bus_read = per_reg[i];
`endif
    end
    case (word)
      W_CTRL:  data_bus_read = 32'(en_reg);
      W_PEND:  data_bus_read = 32'(pend_reg);
      W_MASK:  data_bus_read = 32'(mask_reg);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systick_alarm.sv
// Self-checking bench for systick_alarm: register reset, one-shot, wrap, past alarm,
// collisions, periodic reload (ALARM_PERIODIC_EN) and asynchronous reset.
module tb_systick_alarm;

  localparam logic [31:0] A_CMP0 = 32'h00;
  localparam logic [31:0] A_CMP1 = 32'h04;
  localparam logic [31:0] A_CMP2 = 32'h08;
  localparam logic [31:0] A_CMP3 = 32'h0C;
  localparam logic [31:0] A_PER0 = 32'h10;
  localparam logic [31:0] A_CTRL = 32'h20;
  localparam logic [31:0] A_PEND = 32'h24;
  localparam logic [31:0] A_MASK = 32'h28;

  logic        clk;
  logic        reset;
  logic [31:0] tick;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        sel;
  logic [1:0]  mode;
  logic        irq;

  int n_vec = 0;
  int n_mis = 0;
  int unsigned pc;
  logic [31:0] exp_q[$];
  logic [31:0] hit_q[$];

  systick_alarm #(.NUM_CHANNELS(4)) dut (
    .clk(clk),
    .reset(reset),
    .tick_count(tick),
    .data_bus_read(rdata),
    .data_bus_write(wdata),
    .data_bus_addr(addr),
    .data_bus_select(sel),
    .data_bus_mode(mode),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedges since reset release; the next posedge evaluates channel pc % 4.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 0;
    else pc <= pc + 1;
  end

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; sel = 1'b1; mode = 2'b01;
    #1;
    d = rdata;
    sel = 1'b0; mode = 2'b00;
    $display("rd  %h -> %h", a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; sel = 1'b1; mode = 2'b10;
    $display("wr  %h <= %h", a, d);
    @(negedge clk);
    sel = 1'b0; mode = 2'b00;
  endtask

  task automatic wait_phase(input int ch);
    int k;
    k = 0;
    while ((pc % 4) != ch && k < 8) begin
      @(negedge clk);
      k++;
    end
    if ((pc % 4) != ch) begin
      n_vec++; n_mis++;
      $display("FAIL wait_phase: phase %0d, want %0d", pc % 4, ch);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d, e;
    tick = 32'd0;
    wr(A_CMP0, 32'hDEADBEEF);
    wr(A_CMP3, 32'h12345678);
    wr(A_PER0, 32'h5);
    wr(A_MASK, 32'hF);
    wr(A_CTRL, 32'h1);
    repeat (6) @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_mis++; $display("FAIL reset_pre_irq: got %b want 1", irq); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 11; i++) begin
      rd(32'(4 * i), d);
      e = exp_q.pop_front();
      n_vec++;
      if (d !== e) begin n_mis++; $display("FAIL reset_reg%0d: got %h want %h", i, d, e); end
    end
    n_vec++;
    if (irq !== 1'b0) begin n_mis++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    tick = 32'd95;
    wr(A_CMP0, 32'd100);
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h1);
    for (int t = 95; t <= 105; t++) begin
      rd(A_PEND, d);
      if (t <= 100 || t >= 104) begin
        n_vec++;
        if (d !== ((t >= 104) ? 32'h1 : 32'h0)) begin
          n_mis++; $display("FAIL oneshot_pend_t%0d: got %h want %h", t, d, (t >= 104) ? 32'h1 : 32'h0);
        end
      end
      tick = 32'(t);
      @(negedge clk);
    end
    n_vec++;
    if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    rd(A_CTRL, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL oneshot_ctrl: got %h want 0", d); end
    wr(A_PEND, 32'h1);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL oneshot_w1c: got %h want 0", d); end
    n_vec++;
    if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_irq_lag: got %b want 1", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_mis++; $display("FAIL oneshot_irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    tick = 32'hFFFFFFFE;
    wr(A_CMP1, 32'h00000002);
    wr(A_CTRL, 32'h2);
    repeat (8) @(negedge clk);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL wrap_early: got %h want 0", d); end
    tick = 32'h00000002;
    repeat (4) @(negedge clk);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h2) begin n_mis++; $display("FAIL wrap_hit: got %h want 2", d); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_mis++; $display("FAIL wrap_masked_irq: got %b want 0", irq); end
    wr(A_PEND, 32'hF);
  endtask

  task automatic test_past_alarm;
    logic [31:0] d;
    wr(A_MASK, 32'h0);
    tick = 32'd500;
    wr(A_CMP2, 32'd400);
    wr(A_CTRL, 32'h4);
    repeat (4) @(negedge clk);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h4) begin n_mis++; $display("FAIL past_pend: got %h want 4", d); end
    repeat (2) @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_mis++; $display("FAIL past_irq: got %b want 0", irq); end
    wr(A_PEND, 32'hF);
  endtask

  task automatic test_collision;
    logic [31:0] d;
    tick = 32'd1000;
    wr(A_CMP3, 32'd900);
    wait_phase(2);
    wr(A_CTRL, 32'h8);
    wr(A_PEND, 32'h8);       // lands on the ch3 evaluation edge
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h8) begin n_mis++; $display("FAIL coll_w1c_vs_set: got %h want 8", d); end
    rd(A_CTRL, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL coll_ctrl: got %h want 0", d); end
    wr(A_PEND, 32'h8);
    wait_phase(2);
    wr(A_CTRL, 32'h8);
    wr(A_CMP3, 32'd950);     // bus write on ch3 evaluation discards that hit
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL coll_cmp_discard: got %h want 0", d); end
    repeat (3) @(negedge clk);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL coll_before_lap: got %h want 0", d); end
    @(negedge clk);
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h8) begin n_mis++; $display("FAIL coll_retry: got %h want 8", d); end
    rd(A_CMP3, d);
    n_vec++;
    if (d !== 32'd950) begin n_mis++; $display("FAIL coll_cmp3: got %h want %h", d, 32'd950); end
    wr(A_PEND, 32'hF);
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_periodic;
    logic [31:0] d, e, obs;
    int hits, want_hits;
    logic [31:0] want_cmp, want_ctrl, want_per;
`ifdef ALARM_PERIODIC_EN
    want_hits = 3; want_cmp = 32'd40; want_ctrl = 32'h1; want_per = 32'd10;
    hit_q.push_back(32'd10); hit_q.push_back(32'd20); hit_q.push_back(32'd30);
`else
    want_hits = 1; want_cmp = 32'd10; want_ctrl = 32'h0; want_per = 32'd0;
    hit_q.push_back(32'd10);
`endif
    tick = 32'd0;
    wr(A_PEND, 32'hF);
    wr(A_CMP0, 32'd10);
    wr(A_PER0, 32'd10);
    rd(A_PER0, d);
    n_vec++;
    if (d !== want_per) begin n_mis++; $display("FAIL per0_read: got %h want %h", d, want_per); end
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h1);
    hits = 0;
    for (int t = 0; t <= 35; t++) begin
      rd(A_PEND, d);
      obs = tick;
      if (d[0]) begin
        hits++;
        n_vec++;
        if (hit_q.size() == 0) begin
          n_mis++; $display("FAIL periodic_extra_hit: got hit at tick %0d want none", obs);
        end else begin
          e = hit_q.pop_front();
          if (!(obs >= e && obs <= e + 32'd4)) begin
            n_mis++; $display("FAIL periodic_hit_tick: got %0d want %0d..%0d", obs, e, e + 32'd4);
          end
        end
        addr = A_PEND; wdata = 32'h1; sel = 1'b1; mode = 2'b10;
      end
      tick = 32'(t);
      @(negedge clk);
      sel = 1'b0; mode = 2'b00;
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (hits != want_hits) begin n_mis++; $display("FAIL periodic_hits: got %0d want %0d", hits, want_hits); end
    rd(A_CMP0, d);
    n_vec++;
    if (d !== want_cmp) begin n_mis++; $display("FAIL periodic_cmp0: got %h want %h", d, want_cmp); end
    rd(A_CTRL, d);
    n_vec++;
    if (d !== want_ctrl) begin n_mis++; $display("FAIL periodic_ctrl: got %h want %h", d, want_ctrl); end
    hit_q.delete();
    wr(A_CTRL, 32'h0);
    wr(A_PEND, 32'hF);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    tick = 32'd100;
    wr(A_CMP0, 32'd50);
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_mis++; $display("FAIL async_pre_irq: got %b want 1", irq); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (irq !== 1'b0) begin n_mis++; $display("FAIL async_irq_drop: got %b want 0", irq); end
    rd(A_PEND, d);
    n_vec++;
    if (d !== 32'h0) begin n_mis++; $display("FAIL async_pend: got %h want 0", d); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; tick = '0; sel = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset;
    test_one_shot;
    test_wrap;
    test_past_alarm;
    test_collision;
    test_periodic;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
